munoc_rfifo_downsizer: RTL and testbench
========================================

MUNOC_RFIFO_DOWNSIZER -- requirements
Module: munoc_rfifo_downsizer

Interface
REQ-001 Parameter BW_IN, default 64, width of a word popped from the FIFO read side.
REQ-002 Parameter RATIO, default 4, output beats per input word; RATIO>=2 and BW_IN divisible by RATIO.
REQ-003 Derived BW_OUT = BW_IN/RATIO; counter width BW_CNT = clog2(RATIO).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rstnn  input  1  asynchronous, active-low reset.
REQ-006 fifo_rready  input  1  FIFO non-empty; fifo_rdata valid while high (first-word-fall-through).
REQ-007 fifo_rrequest  output  1  pop strobe to FIFO read side, one word per high cycle.
REQ-008 fifo_rdata  input  BW_IN  head-of-FIFO word.
REQ-009 ovalid  output  1  output beat valid.
REQ-010 oready  input  1  downstream accepts beat.
REQ-011 odata  output  BW_OUT  output beat.
REQ-012 olast  output  1  final beat of a word (present only under MUNOC_DOWNSIZER_LAST_EN).

Function
REQ-013 FSM states IDLE and SEND; registers: state, word buffer (BW_IN), beat counter cnt (BW_CNT).
REQ-014 IDLE: fifo_rrequest = fifo_rready; on a pop edge load buffer from fifo_rdata, cnt<=0, go SEND.
REQ-015 Latency: word popped at edge N -> ovalid=1 with beat 0 in the cycle after edge N.
REQ-016 SEND: ovalid=1; odata = buffer[cnt*BW_OUT +: BW_OUT], LSB slice first.
REQ-017 SEND, ovalid&oready, cnt<RATIO-1: cnt<=cnt+1, stay SEND.
REQ-018 SEND, ovalid&oready, cnt==RATIO-1, fifo_rready=1: fifo_rrequest=1 same cycle, reload buffer, cnt<=0, stay SEND (no bubble).
REQ-019 SEND, ovalid&oready, cnt==RATIO-1, fifo_rready=0: go IDLE, ovalid=0 next cycle.
REQ-020 fifo_rrequest never asserted while fifo_rready=0, nor in SEND except under REQ-018.
REQ-021 Backpressure: while ovalid=1 and oready=0, odata, cnt and buffer hold unchanged; ovalid never drops before handshake.
REQ-022 Sustained throughput with oready=1 and FIFO non-empty: one beat per cycle, one pop per RATIO cycles.
REQ-023 fifo_rdata ignored in all cycles without fifo_rrequest=1.

Reset
REQ-024 rstnn low: state IDLE, cnt 0, buffer 0, ovalid 0, odata 0, olast 0, immediately and asynchronously.
REQ-025 fifo_rrequest forced 0 combinationally while rstnn=0.
REQ-026 Reset mid-word discards remaining beats; the next word after release starts at beat 0.

Configuration
REQ-027 Macro MUNOC_DOWNSIZER_LAST_EN defined: port olast exists, olast = ovalid & (cnt==RATIO-1).
REQ-028 Macro undefined: no olast port, no olast logic; all other behaviour identical.

Verification (BW_IN=32, RATIO=4, LAST_EN defined)
REQ-029 FIFO holds 0x44332211, oready=1 -> pop at edge N; beats 0x11,0x22,0x33,0x44 in cycles N+1..N+4; olast only on 0x44; then ovalid=0.
REQ-030 FIFO holds 0x44332211 then 0x88776655, oready=1 -> 8 beats in 8 consecutive cycles, second pop coincides with beat 0x44 handshake.
REQ-031 oready=0 for 3 cycles while beat 0x22 presented -> ovalid=1 and odata=0x22 held all 3 cycles, no pop, then 0x33 follows.
REQ-032 fifo_rready=0 for 20 cycles -> fifo_rrequest=0 and ovalid=0 throughout.
REQ-033 rstnn pulsed low after beat 0x11 accepted -> ovalid=0 at once, fifo_rrequest=0 during reset; next word 0xDDCCBBAA emits 0xAA first.

Source files
------------

// File: rtl/munoc_rfifo_downsizer.sv
// Purpose : splits each BW_IN-bit word popped from a first-word-fall-through FIFO
//           into RATIO beats of BW_OUT = BW_IN/RATIO bits, least-significant slice first.
// Latency : a word popped at edge N is presented as beat 0 in the following cycle;
//           the next word is popped on the last-beat handshake, so there is no bubble.
// Backpr. : while ovalid & !oready the beat, beat counter and word buffer all hold.
// Option  : define MUNOC_DOWNSIZER_LAST_EN to add olast (high on the final beat of a word).
// Ports   : clk, rstnn (async, active-low)
//           fifo_rready / fifo_rrequest / fifo_rdata  - FIFO read side (rready = non-empty)
//           ovalid / oready / odata [/ olast]         - downsized output stream
// Params  : BW_IN (word width), RATIO (beats per word, >= 2, must divide BW_IN).
module munoc_rfifo_downsizer #(
  parameter  int BW_IN  = 64,
  parameter  int RATIO  = 4,
  localparam int BW_OUT = BW_IN / RATIO,
  localparam int BW_CNT = $clog2(RATIO)
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              fifo_rready,
  output logic              fifo_rrequest,
  input  logic [BW_IN-1:0]  fifo_rdata,
  output logic              ovalid,
  input  logic              oready,
  output logic [BW_OUT-1:0] odata
`ifdef MUNOC_DOWNSIZER_LAST_EN
  ,
  output logic              olast
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(RATIO - 1);

  state_t                       state_q, state_d;
  // Word buffer viewed as RATIO slices so the beat select is a plain index.
  logic [RATIO-1:0][BW_OUT-1:0] buf_q, buf_d;
  logic [BW_CNT-1:0]            cnt_q, cnt_d;
  logic                         ovalid_q, ovalid_d;
  logic                         pop;
  logic                         beat_last;

  assign beat_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rready) begin
          pop      = 1'b1;
          buf_d    = fifo_rdata;
          cnt_d    = '0;
          state_d  = SEND;
          ovalid_d = 1'b1;
        end
      end
      SEND: begin
        // ovalid is always high in SEND, so oready alone completes a handshake.
        if (oready) begin
          if (!beat_last) begin
            cnt_d = cnt_q + BW_CNT'(1);
          end else if (fifo_rready) begin
            // Reload on the last-beat handshake to keep one beat per cycle.
            pop   = 1'b1;
            buf_d = fifo_rdata;
            cnt_d = '0;
          end else begin
            state_d  = IDLE;
            ovalid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Gated by rstnn so the FIFO is never popped while the block is held in reset.
  assign fifo_rrequest = pop & rstnn;
  assign ovalid        = ovalid_q;
  assign odata         = buf_q[cnt_q];

`ifdef MUNOC_DOWNSIZER_LAST_EN
  assign olast = ovalid_q & beat_last;
`endif

endmodule

// File: tb/tb_munoc_rfifo_downsizer.sv
// Bench for munoc_rfifo_downsizer at BW_IN=32, RATIO=4: directed scenarios plus a
// randomized run scored against a FIFO-word / beat-queue model.
// olast is connected and checked only when MUNOC_DOWNSIZER_LAST_EN is defined.
module tb_munoc_rfifo_downsizer;
  localparam int BW_IN  = 32;
  localparam int RATIO  = 4;
  localparam int BW_OUT = BW_IN / RATIO;

  logic              clk;
  logic              rstnn;
  logic              fifo_rready;
  logic              fifo_rrequest;
  logic [BW_IN-1:0]  fifo_rdata;
  logic              ovalid;
  logic              oready;
  logic [BW_OUT-1:0] odata;
`ifdef MUNOC_DOWNSIZER_LAST_EN
  logic              olast;
  logic              obs_last;
`endif

  int total;
  int bad;

  // FIFO contents; q[0] is the head shown on fifo_rdata.
  logic [BW_IN-1:0] q[$];

  logic              obs_vld, obs_req, obs_rdy, obs_ordy;
  logic [BW_OUT-1:0] obs_dat;

  munoc_rfifo_downsizer #(.BW_IN(BW_IN), .RATIO(RATIO)) dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .fifo_rready   (fifo_rready),
    .fifo_rrequest (fifo_rrequest),
    .fifo_rdata    (fifo_rdata),
    .ovalid        (ovalid),
    .oready        (oready),
    .odata         (odata)
`ifdef MUNOC_DOWNSIZER_LAST_EN
    ,
    .olast         (olast)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat i of a word is its i-th BW_OUT-bit slice counted from the LSB.
  function automatic logic [BW_OUT-1:0] beat(input logic [BW_IN-1:0] w, input int i);
    return w[BW_OUT*i +: BW_OUT];
  endfunction

  // Present the FIFO head; with an empty FIFO the data bus carries garbage.
  task automatic refresh();
    fifo_rready = (q.size() != 0);
    fifo_rdata  = (q.size() != 0) ? q[0] : $urandom;
  endtask

  // One clock: sample outputs at the falling edge, then apply the pop after the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_vld  = ovalid;
    obs_dat  = odata;
    obs_req  = fifo_rrequest;
    obs_rdy  = fifo_rready;
    obs_ordy = oready;
`ifdef MUNOC_DOWNSIZER_LAST_EN
    obs_last = olast;
`endif
    @(posedge clk);
    #1;
    if (obs_req && q.size() != 0) q.delete(0);
    refresh();
  endtask

  // Run with oready=1 until the FIFO is empty and the block is idle (bounded).
  task automatic drain(output bit ok);
    ok = 1'b0;
    oready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (!obs_vld && !obs_req && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rstnn = 1'b0;
    q.push_back(32'h12345678);
    refresh();
    oready = 1'b1;
    #2;
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
    total++; if (odata !== '0) begin bad++; $display("FAIL reset_odata got=%h exp=00", odata); end
    total++; if (fifo_rrequest !== 1'b0) begin bad++; $display("FAIL reset_rrequest got=%b exp=0", fifo_rrequest); end
`ifdef MUNOC_DOWNSIZER_LAST_EN
    total++; if (olast !== 1'b0) begin bad++; $display("FAIL reset_olast got=%b exp=0", olast); end
`endif
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (obs_req !== 1'b0 || obs_vld !== 1'b0) begin
        bad++; $display("FAIL reset_hold cyc%0d req=%b vld=%b exp req=0 vld=0", i, obs_req, obs_vld);
      end
    end
    q.delete();
    refresh();
    rstnn = 1'b1;
    cycle();
    total++;
    if (obs_req !== 1'b0 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL reset_release req=%b vld=%b exp req=0 vld=0", obs_req, obs_vld);
    end
  endtask

  task automatic test_single();
    logic [BW_IN-1:0] w;
    w = 32'h44332211;
    oready = 1'b1;
    q.push_back(w);
    refresh();
    cycle();
    total++;
    if (obs_req !== 1'b1 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL single_pop req=%b vld=%b exp req=1 vld=0", obs_req, obs_vld);
    end
    for (int i = 0; i < RATIO; i++) begin
      cycle();
      total++;
      if (obs_vld !== 1'b1 || obs_dat !== beat(w, i) || obs_req !== 1'b0) begin
        bad++; $display("FAIL single_beat%0d vld=%b dat=%h req=%b exp vld=1 dat=%h req=0",
                        i, obs_vld, obs_dat, obs_req, beat(w, i));
      end
`ifdef MUNOC_DOWNSIZER_LAST_EN
      total++;
      if (obs_last !== (i == RATIO - 1)) begin
        bad++; $display("FAIL single_last%0d got=%b exp=%b", i, obs_last, (i == RATIO - 1));
      end
`endif
    end
    cycle();
    total++; if (obs_vld !== 1'b0) begin bad++; $display("FAIL single_end vld=%b exp=0", obs_vld); end
  endtask

  task automatic test_back_to_back();
    logic [BW_IN-1:0] w[2];
    w[0] = 32'h44332211;
    w[1] = 32'h88776655;
    oready = 1'b1;
    q.push_back(w[0]);
    q.push_back(w[1]);
    refresh();
    cycle();
    total++;
    if (obs_req !== 1'b1 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL b2b_pop req=%b vld=%b exp req=1 vld=0", obs_req, obs_vld);
    end
    for (int k = 0; k < 2 * RATIO; k++) begin
      cycle();
      total++;
      if (obs_vld !== 1'b1 || obs_dat !== beat(w[k / RATIO], k % RATIO) || obs_req !== (k == RATIO - 1)) begin
        bad++; $display("FAIL b2b_beat%0d vld=%b dat=%h req=%b exp vld=1 dat=%h req=%b",
                        k, obs_vld, obs_dat, obs_req, beat(w[k / RATIO], k % RATIO), (k == RATIO - 1));
      end
`ifdef MUNOC_DOWNSIZER_LAST_EN
      total++;
      if (obs_last !== (k % RATIO == RATIO - 1)) begin
        bad++; $display("FAIL b2b_last%0d got=%b exp=%b", k, obs_last, (k % RATIO == RATIO - 1));
      end
`endif
    end
    cycle();
    total++;
    if (obs_vld !== 1'b0 || obs_req !== 1'b0) begin
      bad++; $display("FAIL b2b_end vld=%b req=%b exp vld=0 req=0", obs_vld, obs_req);
    end
  endtask

  task automatic test_backpressure();
    logic [BW_IN-1:0] w;
    bit ok;
    w = 32'h44332211;
    oready = 1'b1;
    q.push_back(w);
    refresh();
    cycle();                         // pop
    q.push_back(32'h88776655);       // keep the FIFO non-empty during the stall
    refresh();
    cycle();                         // beat 0 accepted
    total++;
    if (obs_dat !== beat(w, 0)) begin bad++; $display("FAIL bp_first dat=%h exp=%h", obs_dat, beat(w, 0)); end
    oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (obs_vld !== 1'b1 || obs_dat !== beat(w, 1) || obs_req !== 1'b0) begin
        bad++; $display("FAIL bp_stall%0d vld=%b dat=%h req=%b exp vld=1 dat=%h req=0",
                        i, obs_vld, obs_dat, obs_req, beat(w, 1));
      end
    end
    oready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      cycle();
      total++;
      if (obs_vld !== 1'b1 || obs_dat !== beat(w, i)) begin
        bad++; $display("FAIL bp_resume%0d vld=%b dat=%h exp vld=1 dat=%h", i, obs_vld, obs_dat, beat(w, i));
      end
    end
    drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_drain idle=%b exp=1", ok); end
  endtask

  task automatic test_empty();
    q.delete();
    refresh();
    for (int i = 0; i < 20; i++) begin
      oready = 1'($urandom_range(0, 1));
      cycle();
      total++;
      if (obs_req !== 1'b0 || obs_vld !== 1'b0) begin
        bad++; $display("FAIL empty%0d req=%b vld=%b exp req=0 vld=0", i, obs_req, obs_vld);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [BW_IN-1:0] w;
    bit ok;
    w = 32'hDDCCBBAA;
    oready = 1'b1;
    q.push_back(32'h44332211);
    refresh();
    cycle();                         // pop
    cycle();                         // beat 0x11 accepted
    rstnn = 1'b0;
    q.push_back(w);
    refresh();
    #1;
    total++;
    if (ovalid !== 1'b0 || odata !== '0 || fifo_rrequest !== 1'b0) begin
      bad++; $display("FAIL midrst_async vld=%b dat=%h req=%b exp vld=0 dat=00 req=0", ovalid, odata, fifo_rrequest);
    end
    cycle();
    total++;
    if (obs_req !== 1'b0 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL midrst_hold req=%b vld=%b exp req=0 vld=0", obs_req, obs_vld);
    end
    rstnn = 1'b1;
    cycle();
    total++;
    if (obs_req !== 1'b1 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL midrst_pop req=%b vld=%b exp req=1 vld=0", obs_req, obs_vld);
    end
    cycle();
    total++;
    if (obs_vld !== 1'b1 || obs_dat !== beat(w, 0)) begin
      bad++; $display("FAIL midrst_first vld=%b dat=%h exp vld=1 dat=%h", obs_vld, obs_dat, beat(w, 0));
    end
    drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_drain idle=%b exp=1", ok); end
  endtask

  task automatic test_random();
    logic [BW_OUT-1:0] exp_d[$];
`ifdef MUNOC_DOWNSIZER_LAST_EN
    logic              exp_l[$];
`endif
    logic [BW_IN-1:0]  w;
    logic [BW_OUT-1:0] prev_dat;
    logic              prev_stall;
    prev_stall = 1'b0;
    prev_dat   = '0;
    for (int c = 0; c < 800; c++) begin
      if (c < 600 && $urandom_range(0, 3) == 0 && q.size() < 4) begin
        w = $urandom;
        q.push_back(w);
        for (int i = 0; i < RATIO; i++) begin
          exp_d.push_back(beat(w, i));
`ifdef MUNOC_DOWNSIZER_LAST_EN
          exp_l.push_back(i == RATIO - 1);
`endif
        end
        refresh();
      end
      oready = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      if (obs_req) begin
        total++;
        if (obs_rdy !== 1'b1) begin bad++; $display("FAIL rnd_req_empty cyc%0d rdy=%b exp=1", c, obs_rdy); end
      end
      if (prev_stall) begin
        total++;
        if (obs_vld !== 1'b1 || obs_dat !== prev_dat) begin
          bad++; $display("FAIL rnd_hold cyc%0d vld=%b dat=%h exp vld=1 dat=%h", c, obs_vld, obs_dat, prev_dat);
        end
      end
      if (obs_vld && obs_ordy) begin
        total++;
        if (exp_d.size() == 0) begin
          bad++; $display("FAIL rnd_extra cyc%0d dat=%h exp none", c, obs_dat);
        end else begin
          if (obs_dat !== exp_d[0]) begin
            bad++; $display("FAIL rnd_beat cyc%0d dat=%h exp=%h", c, obs_dat, exp_d[0]);
          end
          exp_d.delete(0);
`ifdef MUNOC_DOWNSIZER_LAST_EN
          total++;
          if (obs_last !== exp_l[0]) begin
            bad++; $display("FAIL rnd_last cyc%0d got=%b exp=%b", c, obs_last, exp_l[0]);
          end
          exp_l.delete(0);
`endif
        end
      end
      prev_stall = obs_vld && !obs_ordy;
      prev_dat   = obs_dat;
    end
    total++;
    if (exp_d.size() != 0 || obs_vld !== 1'b0) begin
      bad++; $display("FAIL rnd_left beats=%0d vld=%b exp beats=0 vld=0", exp_d.size(), obs_vld);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rstnn       = 1'b1;
    oready      = 1'b0;
    fifo_rready = 1'b0;
    fifo_rdata  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_empty();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
